// File: rtl/display7seg_pkg.sv
// Shared types, segment encodings and the hex decoder for the 7-segment mux.
package display7seg_pkg;

  typedef logic [6:0] seg_t;  // {g,f,e,d,c,b,a}, active-low

  localparam seg_t SEG_0     = 7'b1000000;
  localparam seg_t SEG_1     = 7'b1111001;
  localparam seg_t SEG_2     = 7'b0100100;
  localparam seg_t SEG_3     = 7'b0110000;
  localparam seg_t SEG_4     = 7'b0011001;
  localparam seg_t SEG_5     = 7'b0010010;
  localparam seg_t SEG_6     = 7'b0000010;
  localparam seg_t SEG_7     = 7'b1111000;
  localparam seg_t SEG_8     = 7'b0000000;
  localparam seg_t SEG_9     = 7'b0011000;
  localparam seg_t SEG_A     = 7'b0001000;
  localparam seg_t SEG_B     = 7'b0000011;
  localparam seg_t SEG_C     = 7'b1000110;
  localparam seg_t SEG_D     = 7'b0100001;
  localparam seg_t SEG_E     = 7'b0000110;
  localparam seg_t SEG_F     = 7'b0001110;
  localparam seg_t SEG_BLANK = 7'b1111111;

  function automatic seg_t hex_to_seg(input logic [3:0] nib);
    seg_t seg;
    case (nib)
      4'h0:    seg = SEG_0;
      4'h1:    seg = SEG_1;
      4'h2:    seg = SEG_2;
      4'h3:    seg = SEG_3;
      4'h4:    seg = SEG_4;
      4'h5:    seg = SEG_5;
      4'h6:    seg = SEG_6;
      4'h7:    seg = SEG_7;
      4'h8:    seg = SEG_8;
      4'h9:    seg = SEG_9;
      4'ha:    seg = SEG_A;
      4'hb:    seg = SEG_B;
      4'hc:    seg = SEG_C;
      4'hd:    seg = SEG_D;
      4'he:    seg = SEG_E;
      default: seg = SEG_F;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/display7seg_if.sv
// Update bus from the value producer: load strobe, display fields and pending flag.
interface display7seg_if #(
  parameter int unsigned DIGITS = 4
) ();
  logic                  load_i;
  logic [4*DIGITS-1:0]   value_i;
  logic [DIGITS-1:0]     dp_i;
  logic [DIGITS-1:0]     blink_i;
  logic                  lzs_i;
  logic                  pending_o;

  modport master (output load_i, value_i, dp_i, blink_i, lzs_i, input pending_o);
  modport slave  (input load_i, value_i, dp_i, blink_i, lzs_i, output pending_o);
endinterface

// File: rtl/display7seg_scan.sv
// Slot/digit/frame timebase and blink phase. Outputs describe the state being entered at the
// next edge, so pin registers fed from them line up with the scan state.
module display7seg_scan
  import display7seg_pkg::*;
#(
  parameter int unsigned DIGITS       = 4,
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned BLINK_FRAMES = 64,
  localparam int unsigned IdxW  = (DIGITS > 1) ? $clog2(DIGITS) : 1,
  localparam int unsigned SlotW = $clog2(REFRESH_DIV),
  localparam int unsigned FrmW  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [IdxW-1:0] idx_o,
  output logic            slot_first_o,
  output logic            frame_end_o,
  output logic            blink_phase_o
);

  logic [SlotW-1:0] r_slot, w_slot_d;
  logic [IdxW-1:0]  r_idx, w_idx_d;
  logic [FrmW-1:0]  r_frm, w_frm_d;
  logic             r_phase, w_phase_d;
  logic             w_slot_end, w_frame_end;

  always_comb begin
    w_slot_end  = (r_slot == SlotW'(REFRESH_DIV - 1));
    w_frame_end = w_slot_end && (r_idx == IdxW'(DIGITS - 1));
    w_slot_d    = w_slot_end ? '0 : r_slot + SlotW'(1);
    w_idx_d     = r_idx;
    w_frm_d     = r_frm;
    w_phase_d   = r_phase;
    if (w_slot_end) begin
      w_idx_d = w_frame_end ? '0 : r_idx + IdxW'(1);
    end
    if (w_frame_end) begin
      if (r_frm == FrmW'(BLINK_FRAMES - 1)) begin
        w_frm_d   = '0;
        w_phase_d = ~r_phase;
      end else begin
        w_frm_d = r_frm + FrmW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_slot  <= '0;
      r_idx   <= '0;
      r_frm   <= '0;
      r_phase <= 1'b0;
    end else begin
      r_slot  <= w_slot_d;
      r_idx   <= w_idx_d;
      r_frm   <= w_frm_d;
      r_phase <= w_phase_d;
    end
  end

  assign idx_o         = w_idx_d;
  assign slot_first_o  = (w_slot_d == '0);
  assign frame_end_o   = w_frame_end;
  assign blink_phase_o = w_phase_d;

endmodule

// File: rtl/display7seg_mux.sv
// Time-multiplexed common-anode 7-segment driver with frame-synchronous update, blink,
// decimal points and leading-zero suppression.
module display7seg_mux
  import display7seg_pkg::*;
#(
  parameter int unsigned DIGITS       = 4,
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  display7seg_if.slave      upd,
  output seg_t              seg_o,
  output logic              dp_n_o,
  output logic [DIGITS-1:0] an_o
);

  localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [IdxW-1:0] w_idx;
  logic            w_slot_first, w_frame_end, w_blink_phase;

  display7seg_scan #(
    .DIGITS      (DIGITS),
    .REFRESH_DIV (REFRESH_DIV),
    .BLINK_FRAMES(BLINK_FRAMES)
  ) u_scan (
    .clk          (clk),
    .rst_n        (rst_n),
    .idx_o        (w_idx),
    .slot_first_o (w_slot_first),
    .frame_end_o  (w_frame_end),
    .blink_phase_o(w_blink_phase)
  );

  logic [4*DIGITS-1:0] r_pval, r_aval, w_pval_d, w_aval_d;
  logic [DIGITS-1:0]   r_pdp, r_adp, w_pdp_d, w_adp_d;
  logic [DIGITS-1:0]   r_pblk, r_ablk, w_pblk_d, w_ablk_d;
  logic                r_plzs, r_alzs, w_plzs_d, w_alzs_d;
  logic                r_pending, w_pending_d;

  // A load coinciding with the frame boundary bypasses pending and wins over it.
  always_comb begin
    w_pval_d = r_pval;  w_pdp_d = r_pdp;  w_pblk_d = r_pblk;  w_plzs_d = r_plzs;
    w_aval_d = r_aval;  w_adp_d = r_adp;  w_ablk_d = r_ablk;  w_alzs_d = r_alzs;
    w_pending_d = r_pending;
    if (w_frame_end && upd.load_i) begin
      w_aval_d = upd.value_i;  w_adp_d = upd.dp_i;
      w_ablk_d = upd.blink_i;  w_alzs_d = upd.lzs_i;
      w_pending_d = 1'b0;
    end else if (w_frame_end && r_pending) begin
      w_aval_d = r_pval;  w_adp_d = r_pdp;  w_ablk_d = r_pblk;  w_alzs_d = r_plzs;
      w_pending_d = 1'b0;
    end else if (upd.load_i) begin
      w_pval_d = upd.value_i;  w_pdp_d = upd.dp_i;
      w_pblk_d = upd.blink_i;  w_plzs_d = upd.lzs_i;
      w_pending_d = 1'b1;
    end
  end

  logic [DIGITS-1:0] w_zero_hi;
  logic [3:0]        w_nib;
  logic              w_lz_blank, w_bl_blank, w_dp_n_d;
  seg_t              w_seg_d;
  logic [DIGITS-1:0] w_an_d;

  always_comb begin
    logic z;
    z         = 1'b1;
    w_zero_hi = '0;
    // w_zero_hi[k]: nibble k and every nibble above it are zero
    for (int k = int'(DIGITS) - 1; k >= 0; k--) begin
      z            = z & (w_aval_d[4*k +: 4] == 4'h0);
      w_zero_hi[k] = z;
    end
    w_nib      = w_aval_d[{w_idx, 2'b00} +: 4];
    w_lz_blank = w_alzs_d && (w_idx != '0) && w_zero_hi[w_idx];
    w_bl_blank = w_blink_phase && w_ablk_d[w_idx];
    w_seg_d    = (w_lz_blank || w_bl_blank) ? SEG_BLANK : hex_to_seg(w_nib);
    w_dp_n_d   = ~(w_adp_d[w_idx] & ~w_bl_blank);
    w_an_d     = w_slot_first ? '1 : ~(DIGITS'(1) << w_idx);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pval <= '0;  r_pdp <= '0;  r_pblk <= '0;  r_plzs <= 1'b0;
      r_aval <= '0;  r_adp <= '0;  r_ablk <= '0;  r_alzs <= 1'b0;
      r_pending <= 1'b0;
      seg_o     <= SEG_BLANK;
      dp_n_o    <= 1'b1;
      an_o      <= '1;
    end else begin
      r_pval <= w_pval_d;  r_pdp <= w_pdp_d;  r_pblk <= w_pblk_d;  r_plzs <= w_plzs_d;
      r_aval <= w_aval_d;  r_adp <= w_adp_d;  r_ablk <= w_ablk_d;  r_alzs <= w_alzs_d;
      r_pending <= w_pending_d;
      seg_o     <= w_seg_d;
      dp_n_o    <= w_dp_n_d;
      an_o      <= w_an_d;
    end
  end

  assign upd.pending_o = r_pending;

endmodule
